param_stack: RTL and testbench
==============================

Name: param_stack

Overview:
Parametrised LIFO stack and the successor to the fixed 8-bit stack. Width and depth are configurable. Adds a registered pop output with a valid strobe, a combinational peek of the top entry, an occupancy count, an almost-full flag, a push+pop replace operation, a synchronous flush, and sticky overflow/underflow error flags. It sits between a producer/consumer pair as a local scratch store, for example an expression evaluator or a return-address buffer.

Parameters:
DATA_WIDTH, 8, width of each entry in bits (>=1)
DEPTH, 8, number of entries (>=2)
AFULL_LEVEL, DEPTH-1, count at or above which almost_full asserts (1..DEPTH)
CNT_W, $clog2(DEPTH+1), width of count output (derived; do not override)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
push  in  1  push request
pop  in  1  pop request
push_data  in  DATA_WIDTH  data to push
flush  in  1  synchronous clear of contents (highest priority after reset)
err_clr  in  1  clears sticky error flags
pop_data  out  DATA_WIDTH  registered popped value
pop_valid  out  1  one-cycle strobe: pop_data updated this cycle
top_data  out  DATA_WIDTH  combinational peek of top entry; 0 when empty
count  out  CNT_W  number of valid entries
empty  out  1  count==0
full  out  1  count==DEPTH
almost_full  out  1  count>=AFULL_LEVEL
overflow  out  1  sticky: push rejected while full
underflow  out  1  sticky: pop rejected while empty

Behaviour:
- Reset (reset==0, asynchronous): sp=0, pop_data=0, pop_valid=0, overflow=0, underflow=0. Storage contents are not reset. Outputs: empty=1, full=0, count=0, top_data=0, almost_full=(AFULL_LEVEL==0 ? 1 : 0), which is 0 for legal values.
- Internal stack pointer sp (CNT_W bits) equals count. Top entry is mem[sp-1].
- Each rising edge resolves exactly one operation, in this priority order:
  - flush: sp<=0, pop_valid<=0. push/pop are ignored. Error flags are unchanged.
  - push & pop, not empty (REPLACE): pop_data<=mem[sp-1], pop_valid<=1, mem[sp-1]<=push_data, sp unchanged. Legal when full; no overflow.
  - push & pop, empty: push performed (mem[0]<=push_data, sp<=1), pop rejected, underflow<=1, pop_valid<=0.
  - push only, not full: mem[sp]<=push_data, sp<=sp+1.
  - push only, full: rejected, no state change except overflow<=1.
  - pop only, not empty: pop_data<=mem[sp-1], sp<=sp-1, pop_valid<=1.
  - pop only, empty: rejected, underflow<=1, pop_data holds its value, pop_valid<=0.
- pop_valid is 0 on every cycle without an accepted pop. pop_data holds its last value.
- Latency: pop_data is valid one cycle after the pop edge. top_data, count, empty, full and almost_full reflect the post-edge state combinationally from sp.
- Error flags: err_clr clears both flags. If a new error occurs in the same cycle as err_clr, the flag ends at 1 (set wins).
- No wrap-around: sp saturates at 0 and DEPTH by rejection. Storage never overwrites below the top.
- Reset asserted mid-operation aborts the operation immediately. The first edge after release is a normal cycle.

Decomposition:
- Shared package/header stack_pkg: opcode localparams OP_NONE, OP_PUSH, OP_POP, OP_REPLACE, OP_FLUSH; a clog2 helper if the toolflow lacks $clog2.
- Sub-module stack_mem: DEPTH x DATA_WIDTH register file with one synchronous write port and one asynchronous read port, no reset.
- param_stack contains the op decode, the sp counter, the flags and the pop_data register.

Test Plan:
- Reset, then push 0x35, 0xA6, 0x5A on consecutive edges, then pop three times -> pop_data 0x5A, 0xA6, 0x35 with pop_valid high each cycle; count 3,2,1,0; empty=1 at end.
- DEPTH=8: push 8 values -> full=1, almost_full=1 from count 7. A 9th push leaves count=8, top_data unchanged, overflow=1. err_clr -> overflow=0.
- Empty stack: pop -> underflow=1, pop_valid=0, pop_data unchanged. Same-cycle push 0x11+pop -> count=1, top_data=0x11, underflow=1.
- Stack holding 0x01,0x02 (top 0x02): push 0x77+pop -> pop_data=0x02, pop_valid=1, top_data=0x77, count=2. Repeat while full -> no overflow.
- Push 5 entries, assert flush together with push -> count=0, empty=1, top_data=0, pop_valid=0.
- Assert reset asynchronously mid-cycle with count=4 and overflow=1 -> count=0, overflow=0, pop_data=0 before the next clk edge. Normal push on the first edge after release.

Source files
------------

// File: rtl/stack_pkg.sv
// stack_pkg: shared operation codes for the parametrised stack
package stack_pkg;
    localparam logic [2:0] OP_NONE    = 3'd0;
    localparam logic [2:0] OP_PUSH    = 3'd1;
    localparam logic [2:0] OP_POP     = 3'd2;
    localparam logic [2:0] OP_REPLACE = 3'd3;
    localparam logic [2:0] OP_FLUSH   = 3'd4;
endpackage

// File: rtl/stack_mem.sv
// stack_mem: register file with one synchronous write port and one asynchronous read port, no reset
module stack_mem #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [AW-1:0]         waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [AW-1:0]         raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/param_stack.sv
// param_stack: parametrised LIFO with registered pop, peek, occupancy flags and sticky error flags
module param_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 8,
    parameter int AFULL_LEVEL = DEPTH - 1,
    parameter int CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  flush,
    input  logic                  err_clr,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  pop_valid,
    output logic [DATA_WIDTH-1:0] top_data,
    output logic [CNT_W-1:0]      count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_full,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int AW = $clog2(DEPTH);

    logic [CNT_W-1:0]      sp;
    logic [2:0]            op;
    logic [AW-1:0]         top_idx;
    logic [AW-1:0]         waddr;
    logic [DATA_WIDTH-1:0] top_raw;
    logic                  we;
    logic                  pop_ok;
    logic                  push_rej;
    logic                  pop_rej;

    assign count       = sp;
    assign empty       = sp == '0;
    assign full        = sp == CNT_W'(DEPTH);
    assign almost_full = sp >= CNT_W'(AFULL_LEVEL);
    assign top_idx     = AW'(sp - 1'b1);
    assign top_data    = empty ? '0 : top_raw;

    // push+pop on an empty stack falls through to a plain push; the pop half is flagged below
    always_comb begin
        op       = flush                    ? OP_FLUSH   :
                   (push && pop && !empty)  ? OP_REPLACE :
                   (push && !full)          ? OP_PUSH    :
                   (pop && !push && !empty) ? OP_POP     : OP_NONE;
        we       = op == OP_PUSH || op == OP_REPLACE;
        waddr    = op == OP_REPLACE ? top_idx : AW'(sp);
        pop_ok   = op == OP_POP || op == OP_REPLACE;
        push_rej = !flush && push && !pop && full;
        pop_rej  = !flush && pop && empty;
    end

    stack_mem #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (push_data),
        .raddr (top_idx),
        .rdata (top_raw)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sp        <= '0;
            pop_data  <= '0;
            pop_valid <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            sp        <= op == OP_FLUSH ? '0 :
                         op == OP_PUSH  ? sp + 1'b1 :
                         op == OP_POP   ? sp - 1'b1 : sp;
            pop_valid <= pop_ok;
            if (pop_ok) pop_data <= top_raw;
            overflow  <= (overflow && !err_clr) || push_rej;
            underflow <= (underflow && !err_clr) || pop_rej;
        end
    end
endmodule

// File: tb/tb_param_stack.sv
// tb_param_stack: table-driven scoreboard bench for param_stack
module tb_param_stack;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       push = 1'b0, pop = 1'b0, flush = 1'b0, err_clr = 1'b0;
    logic [7:0] push_data = '0;
    logic [7:0] pop_data, top_data;
    logic       pop_valid, empty, full, almost_full, overflow, underflow;
    logic [3:0] count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       push, pop, flush, clr;
        logic [7:0] data;
        logic [3:0] cnt;
        logic [7:0] top;
        logic       pv;
        logic [7:0] pd;
        logic       ov, un;
    } vec_t;

    vec_t vecs[22];
    vec_t sb[$];
    vec_t e;

    param_stack dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .push_data(push_data),
        .flush(flush), .err_clr(err_clr), .pop_data(pop_data), .pop_valid(pop_valid),
        .top_data(top_data), .count(count), .empty(empty), .full(full),
        .almost_full(almost_full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pu, input logic po, input logic fl, input logic cl, input logic [7:0] d);
        @(negedge clk);
        push = pu; pop = po; flush = fl; err_clr = cl; push_data = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; flush = 1'b0; err_clr = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b1,1'b0,1'b0,1'b0,8'h35, 4'd1,8'h35,1'b0,8'h00,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,8'hA6, 4'd2,8'hA6,1'b0,8'h00,1'b0,1'b0};
        vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,8'h5A, 4'd3,8'h5A,1'b0,8'h00,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 4'd2,8'hA6,1'b1,8'h5A,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 4'd1,8'h35,1'b1,8'hA6,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 4'd0,8'h00,1'b1,8'h35,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b0,8'h00, 4'd0,8'h00,1'b0,8'h35,1'b0,1'b1};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,8'h11, 4'd1,8'h11,1'b0,8'h35,1'b0,1'b1};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b1,8'h00, 4'd1,8'h11,1'b0,8'h35,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,8'h22, 4'd2,8'h22,1'b0,8'h35,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'h77, 4'd2,8'h77,1'b1,8'h22,1'b0,1'b0};
        vecs[11] = '{1'b1,1'b0,1'b0,1'b0,8'h03, 4'd3,8'h03,1'b0,8'h22,1'b0,1'b0};
        vecs[12] = '{1'b1,1'b0,1'b0,1'b0,8'h04, 4'd4,8'h04,1'b0,8'h22,1'b0,1'b0};
        vecs[13] = '{1'b1,1'b0,1'b0,1'b0,8'h05, 4'd5,8'h05,1'b0,8'h22,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b0,1'b0,1'b0,8'h06, 4'd6,8'h06,1'b0,8'h22,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b0,1'b0,1'b0,8'h07, 4'd7,8'h07,1'b0,8'h22,1'b0,1'b0};
        vecs[16] = '{1'b1,1'b0,1'b0,1'b0,8'h08, 4'd8,8'h08,1'b0,8'h22,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b0,1'b0,1'b0,8'h09, 4'd8,8'h08,1'b0,8'h22,1'b1,1'b0};
        vecs[18] = '{1'b1,1'b1,1'b0,1'b0,8'hAA, 4'd8,8'hAA,1'b1,8'h08,1'b1,1'b0};
        vecs[19] = '{1'b1,1'b0,1'b0,1'b1,8'h09, 4'd8,8'hAA,1'b0,8'h08,1'b1,1'b0};
        vecs[20] = '{1'b0,1'b0,1'b0,1'b1,8'h00, 4'd8,8'hAA,1'b0,8'h08,1'b0,1'b0};
        vecs[21] = '{1'b1,1'b0,1'b1,1'b0,8'h55, 4'd0,8'h00,1'b0,8'h08,1'b0,1'b0};

        #12;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_afull", 32'(almost_full), 0);
        check("rst_top", 32'(top_data), 0);
        check("rst_pd", 32'(pop_data), 0);
        check("rst_pv", 32'(pop_valid), 0);
        check("rst_ov", 32'(overflow), 0);
        check("rst_un", 32'(underflow), 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            sb.push_back(vecs[i]);
            drive(vecs[i].push, vecs[i].pop, vecs[i].flush, vecs[i].clr, vecs[i].data);
            e = sb.pop_front();
            check($sformatf("v%0d_count", i), 32'(count), 32'(e.cnt));
            check($sformatf("v%0d_top", i), 32'(top_data), 32'(e.top));
            check($sformatf("v%0d_pv", i), 32'(pop_valid), 32'(e.pv));
            check($sformatf("v%0d_pd", i), 32'(pop_data), 32'(e.pd));
            check($sformatf("v%0d_ov", i), 32'(overflow), 32'(e.ov));
            check($sformatf("v%0d_un", i), 32'(underflow), 32'(e.un));
            check($sformatf("v%0d_empty", i), 32'(empty), 32'(e.cnt == 0));
            check($sformatf("v%0d_full", i), 32'(full), 32'(e.cnt == 8));
            check($sformatf("v%0d_afull", i), 32'(almost_full), 32'(e.cnt >= 7));
        end

        // fill past full, then pop down to four so overflow is set and pop_data is nonzero
        for (int i = 0; i < 9; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 8'(8'h40 + i));
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check("pre_count", 32'(count), 4);
        check("pre_ov", 32'(overflow), 1);
        check("pre_pd", 32'(pop_data), 32'h44);
        check("pre_top", 32'(top_data), 32'h43);
        #2;
        reset = 1'b0;
        #1;
        check("async_count", 32'(count), 0);
        check("async_ov", 32'(overflow), 0);
        check("async_pd", 32'(pop_data), 0);
        check("async_empty", 32'(empty), 1);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h66);
        check("post_count", 32'(count), 1);
        check("post_top", 32'(top_data), 32'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
